instr_fetch_seq: RTL and testbench
==================================

Name: instr_fetch_seq

Overview:
- Instruction fetch/sequencing unit that consumes the program counter's `pc` and `upc` outputs.
- Fetches one 16-bit instruction per 4-phase `upc` cycle from a synchronous ROM.
- Latches the instruction into an instruction register and pulses the datapath execute enable.
- Drives `load`/`addr` back to the program counter to implement jumps, conditional branches, halt and (optionally) call/return.

Parameters:
STACK_DEPTH, 4, return-address stack entries (used only with IFS_CALL_STACK_EN); power of 2, 2..16

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
pc  input  8  current program counter
upc  input  2  micro-phase counter (0,1,2,3 repeating)
rom_addr  output  8  instruction ROM address; combinational copy of pc
rom_rd  output  1  ROM read strobe
rom_data  input  16  ROM read data, valid the cycle after rom_rd
zero_flag  input  1  ALU zero flag, sampled in phase 2
ir  output  16  instruction register
ir_valid  output  1  ir holds a fetched instruction
exec_en  output  1  datapath execute strobe
load  output  1  PC load request
addr  output  8  PC load target
halted  output  1  sticky halt indicator
stk_err  output  1  sticky stack overflow/underflow flag

Behaviour:
- Reset: clk and rst only; rst is synchronous and active-high. Takes effect at the next clk edge regardless of upc phase or any in-flight branch.
  - Reset values: ir=16'h0000, ir_valid=0, exec_en=0, load=0, addr=8'h00, halted=0, stk_err=0, stack pointer=0.
  - A load pending in phase 3 is cancelled by reset.
- Instruction format: opcode=ir[15:12], operand=ir[7:0].
- Opcodes:
  - 0 NOP
  - 1 JMP
  - 2 JZ
  - 3 JNZ
  - 4 CALL
  - 5 RET
  - F HLT
  - 6..E are datapath ops.
- Phase behaviour, keyed on upc:
  - upc=0: rom_rd=1 (0 if halted); rom_addr=pc.
  - upc=1: at the closing edge, ir<=rom_data and ir_valid<=1.
  - upc=2 (combinational): exec_en=1 iff opcode in 6..E and not halted.
  - upc=2 (registered at the closing edge):
    - load_next=1 for JMP.
    - load_next=1 for JZ with zero_flag=1.
    - load_next=1 for JNZ with zero_flag=0.
    - load_next=1 for HLT.
    - load_next=1 for CALL/RET per the optional feature.
    - load_next=1 whenever already halted.
    - addr<=operand, or pc for HLT/halted.
  - upc=3: load is high for exactly this cycle, then 0. The PC's load-over-increment priority makes the jump take effect at the same edge upc wraps to 0, with no wasted fetch.
- Halt:
  - HLT sets halted at the end of phase 2.
  - While halted: every phase 3 drives load=1 with addr=pc, so the PC is frozen.
  - While halted, rom_rd and exec_en are held 0 and ir holds its value.
  - Only rst clears halted.
- load is never high outside upc=3.
- addr holds its last value when load=0.
- Not-taken conditional branches behave as NOP, and the PC increments normally.

Optional Feature:
- Macro: IFS_CALL_STACK_EN.
- Defined: STACK_DEPTH x 8 return stack.
  - CALL pushes pc+1 (mod 256) and loads operand.
  - RET pops and loads the popped address.
  - CALL when full: push dropped, jump still taken, stk_err<=1.
  - RET when empty: no load (falls through), stk_err<=1.
  - Stack operations commit at the end of phase 2.
- Undefined: CALL and RET decode as NOP, no stack storage exists, and stk_err is tied to 0.

Test Plan:
- Reset then free-run, ROM[0..2]=NOP: rom_rd high at upc=0; pc 0->1->2 every 4 clocks; load never 1; ir_valid rises after first phase 1.
- ROM[3]=16'h1040 (JMP 0x40): load=1 with addr=8'h40 during the upc=3 of pc=3; next fetch rom_addr=8'h40.
- ROM[5]=16'h2010 (JZ 0x10): with zero_flag=0 then pc=6 and no load; rerun with zero_flag=1 then load/addr=8'h10.
- ROM[8]=16'h6123: exec_en high for exactly one cycle (upc=2), ir=16'h6123; ROM[9]=16'hF000 then halted=1, pc stuck at 9 for 20 clocks, rom_rd=0.
- Assert rst during upc=3 with load high after a JMP: next cycle load=0, ir=0, halted=0.
- With IFS_CALL_STACK_EN and STACK_DEPTH=4:
  - CALL 0x20 at pc=2, then RET: pc 0x20 then back to 0x03.
  - 5 nested CALLs: stk_err=1.
  - RET on empty stack: stk_err=1 and no load.

Source files
------------

// File: rtl/instr_fetch_seq.sv
// Instruction fetch/sequencing unit: fetches one instruction per 4-phase upc cycle and
// issues PC loads for jumps, branches and halt. Define IFS_CALL_STACK_EN to add CALL/RET.
module instr_fetch_seq #(
   parameter int STACK_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  pc,
   input  logic [1:0]  upc,
   output logic [7:0]  rom_addr,
   output logic        rom_rd,
   input  logic [15:0] rom_data,
   input  logic        zero_flag,
   output logic [15:0] ir,
   output logic        ir_valid,
   output logic        exec_en,
   output logic        load,
   output logic [7:0]  addr,
   output logic        halted,
   output logic        stk_err
);

   localparam logic [3:0] OP_JMP  = 4'h1;
   localparam logic [3:0] OP_JZ   = 4'h2;
   localparam logic [3:0] OP_JNZ  = 4'h3;
   localparam logic [3:0] OP_CALL = 4'h4;
   localparam logic [3:0] OP_RET  = 4'h5;
   localparam logic [3:0] OP_HLT  = 4'hF;

   if (STACK_DEPTH < 2 || STACK_DEPTH > 16 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("instr_fetch_seq: STACK_DEPTH must be a power of 2 in 2..16");
   end

   logic [15:0] ir_q, ir_d;
   logic        ir_valid_q, ir_valid_d;
   logic        load_q, load_d;
   logic [7:0]  addr_q, addr_d;
   logic        halted_q, halted_d;
   logic [3:0]  opcode;
   logic [7:0]  operand;
   logic        take;
   logic [7:0]  tgt;

   assign opcode  = ir_q[15:12];
   assign operand = ir_q[7:0];

`ifdef IFS_CALL_STACK_EN
   localparam int SPW = $clog2(STACK_DEPTH);
   localparam logic [SPW:0] SP_FULL = (SPW + 1)'(STACK_DEPTH);
   localparam logic [SPW:0] SP_ONE  = (SPW + 1)'(1);

   logic [7:0]   stk_q [STACK_DEPTH];
   logic [7:0]   stk_d [STACK_DEPTH];
   logic [SPW:0] sp_q, sp_d, sp_dec;
   logic         err_q, err_d;
   logic [7:0]   pc_inc;

   assign pc_inc = pc + 8'd1;
   assign sp_dec = sp_q - SP_ONE;
`endif

   always_comb begin
      ir_d       = ir_q;
      ir_valid_d = ir_valid_q;
      load_d     = 1'b0;
      addr_d     = addr_q;
      halted_d   = halted_q;
      take       = 1'b0;
      tgt        = operand;
`ifdef IFS_CALL_STACK_EN
      stk_d = stk_q;
      sp_d  = sp_q;
      err_d = err_q;
`endif
      case (upc)
         2'd1: begin
            if (!halted_q) begin
               ir_d       = rom_data;
               ir_valid_d = 1'b1;
            end
         end
         2'd2: begin
            // A halted unit keeps reloading the current pc so the counter stays frozen.
            if (halted_q) begin
               take = 1'b1;
               tgt  = pc;
            end else begin
               case (opcode)
                  OP_JMP: take = 1'b1;
                  OP_JZ:  take = zero_flag;
                  OP_JNZ: take = !zero_flag;
                  OP_HLT: begin
                     take     = 1'b1;
                     tgt      = pc;
                     halted_d = 1'b1;
                  end
`ifdef IFS_CALL_STACK_EN
                  OP_CALL: begin
                     take = 1'b1;
                     if (sp_q == SP_FULL) begin
                        err_d = 1'b1;
                     end else begin
                        stk_d[sp_q[SPW-1:0]] = pc_inc;
                        sp_d                 = sp_q + SP_ONE;
                     end
                  end
                  OP_RET: begin
                     if (sp_q == '0) begin
                        err_d = 1'b1;
                     end else begin
                        take = 1'b1;
                        tgt  = stk_q[sp_dec[SPW-1:0]];
                        sp_d = sp_dec;
                     end
                  end
`endif
                  default: ;
               endcase
            end
            load_d = take;
            if (take) addr_d = tgt;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ir_q       <= 16'h0000;
         ir_valid_q <= 1'b0;
         load_q     <= 1'b0;
         addr_q     <= 8'h00;
         halted_q   <= 1'b0;
`ifdef IFS_CALL_STACK_EN
         for (int i = 0; i < STACK_DEPTH; i++) stk_q[i] <= 8'h00;
         sp_q  <= '0;
         err_q <= 1'b0;
`endif
      end else begin
         ir_q       <= ir_d;
         ir_valid_q <= ir_valid_d;
         load_q     <= load_d;
         addr_q     <= addr_d;
         halted_q   <= halted_d;
`ifdef IFS_CALL_STACK_EN
         stk_q <= stk_d;
         sp_q  <= sp_d;
         err_q <= err_d;
`endif
      end
   end

   assign rom_addr = pc;
   assign rom_rd   = (upc == 2'd0) && !halted_q;
   assign exec_en  = (upc == 2'd2) && !halted_q && (opcode >= 4'h6) && (opcode <= 4'hE);
   assign ir       = ir_q;
   assign ir_valid = ir_valid_q;
   assign load     = load_q;
   assign addr     = addr_q;
   assign halted   = halted_q;
`ifdef IFS_CALL_STACK_EN
   assign stk_err  = err_q;
`else
   assign stk_err  = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Bench for instr_fetch_seq: drives a behavioural program counter and ROM, and checks
// every cycle against an instruction-level reference model. Honours IFS_CALL_STACK_EN.
module tb_instr_fetch_seq;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  pc;
   logic [1:0]  upc;
   logic [7:0]  rom_addr;
   logic        rom_rd;
   logic [15:0] rom_data;
   logic        zero_flag;
   logic [15:0] ir;
   logic        ir_valid;
   logic        exec_en;
   logic        load;
   logic [7:0]  addr;
   logic        halted;
   logic        stk_err;

   instr_fetch_seq #(.STACK_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .pc(pc), .upc(upc),
      .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_data(rom_data),
      .zero_flag(zero_flag), .ir(ir), .ir_valid(ir_valid), .exec_en(exec_en),
      .load(load), .addr(addr), .halted(halted), .stk_err(stk_err)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // reference model state
   logic [15:0] rom [256];
   bit          m_halted, m_ir_valid, m_load, m_err;
   logic [15:0] m_ir;
   logic [7:0]  m_addr;
   logic [7:0]  m_stk [$];
   logic [7:0]  trace [$];
   logic [7:0]  exp_q [$];
   int          zf_mode;

   task automatic model_reset();
      m_halted = 0; m_ir_valid = 0; m_load = 0; m_err = 0;
      m_ir = 16'h0000; m_addr = 8'h00;
      m_stk.delete();
   endtask

   function automatic bit is_dp(input logic [3:0] op);
      return op >= 4'h6 && op <= 4'hE;
   endfunction

   task automatic check_outputs();
      chk("rom_addr", rom_addr, pc);
      chk("rom_rd",   rom_rd,   upc == 2'd0 && !m_halted);
      chk("exec_en",  exec_en,  upc == 2'd2 && !m_halted && is_dp(m_ir[15:12]));
      chk("load",     load,     m_load);
      chk("addr",     addr,     m_addr);
      chk("ir",       ir,       m_ir);
      chk("ir_valid", ir_valid, m_ir_valid);
      chk("halted",   halted,   m_halted);
      chk("stk_err",  stk_err,  m_err);
   endtask

   // Instruction-level decision taken when an instruction finishes its decode phase.
   task automatic model_decide();
      logic [3:0] op;
      bit         take;
      logic [7:0] tgt;
      op   = m_ir[15:12];
      take = 0;
      tgt  = m_ir[7:0];
      if (m_halted) begin
         take = 1; tgt = pc;
      end else begin
         case (op)
            4'h1: take = 1;
            4'h2: take = zero_flag;
            4'h3: take = !zero_flag;
            4'hF: begin take = 1; tgt = pc; m_halted = 1; end
`ifdef IFS_CALL_STACK_EN
            4'h4: begin
               take = 1;
               if (m_stk.size() == DEPTH) m_err = 1;
               else m_stk.push_back(8'(pc + 8'd1));
            end
            4'h5: begin
               if (m_stk.size() == 0) m_err = 1;
               else begin take = 1; tgt = m_stk.pop_back(); end
            end
`endif
            default: ;
         endcase
      end
      m_load = take;
      if (take) m_addr = tgt;
   endtask

   task automatic tick(input bit do_rst);
      logic       rd, ld;
      logic [7:0] ra, ad;
      @(negedge clk);
      check_outputs();
      rd = rom_rd; ra = rom_addr; ld = load; ad = addr;
      rst = do_rst;
      @(posedge clk);
      #1;
      if (do_rst) begin
         model_reset();
         rst = 1'b0;
         pc  = 8'h00;
         upc = 2'd0;
      end else begin
         case (upc)
            2'd1: if (!m_halted) begin m_ir = rom[pc]; m_ir_valid = 1; end
            2'd2: model_decide();
            2'd3: m_load = 0;
            default: ;
         endcase
         if (rd) rom_data = rom[ra];
         if (upc == 2'd3) begin
            pc = ld ? ad : 8'(pc + 8'd1);
            trace.push_back(pc);
         end
         upc = upc + 2'd1;
      end
      zero_flag = (zf_mode == 2) ? 1'($urandom_range(0, 1)) : (zf_mode == 1);
   endtask

   task automatic check_trace(input string tag);
      chk({tag, "_len"}, trace.size() >= exp_q.size(), 1);
      for (int i = 0; i < exp_q.size() && i < trace.size(); i++) chk(tag, trace[i], exp_q[i]);
   endtask

   task automatic restart(input int zm);
      zf_mode = zm;
      tick(1);
      trace.delete();
   endtask

   task automatic load_directed_rom();
      for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
      rom[3]    = 16'h1040;
      rom[8'h40] = 16'h1005;
      rom[5]    = 16'h2010;
      rom[6]    = 16'h1008;
      rom[8]    = 16'h6123;
      rom[9]    = 16'hF000;
      rom[8'h10] = 16'hF000;
   endtask

   initial begin
      int  n;
      bit  found;
      logic [3:0] op;
      rst = 1'b1; pc = 8'h00; upc = 2'd0; rom_data = 16'h0000; zero_flag = 1'b0;
      zf_mode = 0;
      model_reset();
      load_directed_rom();
      @(posedge clk); #1;
      rst = 1'b0;

      // straight-line fetch, JMP, untaken JZ, datapath op, halt
      trace.delete();
      for (int i = 0; i < 80; i++) tick(0);
      exp_q = '{8'h01, 8'h02, 8'h03, 8'h40, 8'h05, 8'h06, 8'h08, 8'h09, 8'h09, 8'h09};
      check_trace("trace_jz0");
      chk("halt_pc", pc, 8'h09);

      // taken JZ
      restart(1);
      for (int i = 0; i < 60; i++) tick(0);
      exp_q = '{8'h01, 8'h02, 8'h03, 8'h40, 8'h05, 8'h10, 8'h10};
      check_trace("trace_jz1");

      // reset while a jump load is pending in phase 3
      restart(0);
      found = 0;
      n = 0;
      while (!found && n < 100) begin
         if (upc == 2'd3 && m_load) found = 1;
         else begin tick(0); n++; end
      end
      chk("rst_wait", found, 1);
      tick(1);
      @(negedge clk);
      chk("rst_load",   load,   0);
      chk("rst_ir",     ir,     16'h0000);
      chk("rst_halted", halted, 0);

`ifdef IFS_CALL_STACK_EN
      for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
      rom[2] = 16'h4020; rom[8'h20] = 16'h5000;
      rom[3] = 16'h4030; rom[8'h30] = 16'h4031; rom[8'h31] = 16'h4032;
      rom[8'h32] = 16'h4033; rom[8'h33] = 16'h4034; rom[8'h34] = 16'hF000;
      restart(2);
      for (int i = 0; i < 60; i++) tick(0);
      exp_q = '{8'h01, 8'h02, 8'h20, 8'h03, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h34};
      check_trace("trace_call");
      chk("ovf_err", stk_err, 1);

      for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
      rom[0] = 16'h5000; rom[1] = 16'hF000;
      restart(2);
      for (int i = 0; i < 20; i++) tick(0);
      chk("unf_pc",  pc,      8'h01);
      chk("unf_err", stk_err, 1);
`endif

      // randomized programs with occasional resets on a pending load
      for (int seg = 0; seg < 6; seg++) begin
         for (int i = 0; i < 256; i++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'hF && $urandom_range(0, 7) != 0) op = 4'h0;
            rom[i] = {op, 4'($urandom), 8'($urandom)};
         end
         restart(2);
         for (int i = 0; i < 300; i++)
            tick(upc == 2'd3 && m_load && $urandom_range(0, 30) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
